// File: rtl/aes_pkg.sv
// Shared definitions for the RAM stage sequencer: FSM encodings,
// stage-index width and the "next enabled stage" search helper.
package aes_pkg;

  // Sequencer FSM states
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_NEXT = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } seq_state_t;

  // Width of a stage index (also the err_stage port width)
  localparam int ERR_STAGE_W = 4;

  // Largest number of stages a sequencer may own
  localparam int MAX_STAGES = 16;

  // Result of searching a stage mask for the next set bit
  typedef struct packed {
    logic                   found;
    logic [ERR_STAGE_W-1:0] idx;
  } stage_pick_t;

  // Lowest set bit of mask at or above position from; found=0 when none.
  // from is one bit wider than an index so "past the last stage" is expressible.
  function automatic stage_pick_t next_set_bit(input logic [MAX_STAGES-1:0] mask,
                                               input logic [ERR_STAGE_W:0]  from);
    stage_pick_t res;
    res = '{found: 1'b0, idx: {ERR_STAGE_W{1'b0}}};
    for (int i = MAX_STAGES - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(from))) begin
        res.found = 1'b1;
        res.idx   = ERR_STAGE_W'(i);
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/stage_bus_mux.sv
// Selects one stage's RAM port signals out of the flattened per-stage buses.
// The first selected stage wins outright; buses are never OR-combined, and
// everything is driven to zero when valid is low.
module stage_bus_mux #(
  parameter int NUM_STAGES = 3,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic [NUM_STAGES-1:0]            sel,
  input  logic                             valid,
  input  logic [NUM_STAGES*ADDR_WIDTH-1:0] st_addr_a,
  input  logic [NUM_STAGES*ADDR_WIDTH-1:0] st_addr_b,
  input  logic [NUM_STAGES-1:0]            st_we_a,
  input  logic [NUM_STAGES-1:0]            st_we_b,
  input  logic [NUM_STAGES*DATA_WIDTH-1:0] st_data_a,
  input  logic [NUM_STAGES*DATA_WIDTH-1:0] st_data_b,
  output logic [ADDR_WIDTH-1:0]            addr_a,
  output logic [ADDR_WIDTH-1:0]            addr_b,
  output logic                             we_a,
  output logic                             we_b,
  output logic [DATA_WIDTH-1:0]            data_a,
  output logic [DATA_WIDTH-1:0]            data_b
);

  logic hit_s;

  // Route exactly one stage's slices to the RAM ports, zero otherwise
  always_comb begin
    hit_s  = 1'b0;
    addr_a = {ADDR_WIDTH{1'b0}};
    addr_b = {ADDR_WIDTH{1'b0}};
    we_a   = 1'b0;
    we_b   = 1'b0;
    data_a = {DATA_WIDTH{1'b0}};
    data_b = {DATA_WIDTH{1'b0}};
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (valid && sel[k] && !hit_s) begin
        hit_s  = 1'b1;
        addr_a = st_addr_a[k*ADDR_WIDTH +: ADDR_WIDTH];
        addr_b = st_addr_b[k*ADDR_WIDTH +: ADDR_WIDTH];
        we_a   = st_we_a[k];
        we_b   = st_we_b[k];
        data_a = st_data_a[k*DATA_WIDTH +: DATA_WIDTH];
        data_b = st_data_b[k*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        hit_s = hit_s;
      end
    end
  end

endmodule

// File: rtl/ram_stage_sequencer.sv
// Runs a masked sequence of stages that share one dual-port RAM. Each
// enabled stage gets an exclusive enable until it reports finished, with a
// one-cycle gap between stages and an optional per-stage watchdog.
module ram_stage_sequencer
  import aes_pkg::*;
#(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_STAGES    = 3,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [NUM_STAGES-1:0]            stage_mask,
  input  logic [TIMEOUT_WIDTH-1:0]         timeout,
  output logic [NUM_STAGES-1:0]            st_ena,
  input  logic [NUM_STAGES-1:0]            st_finished,
  input  logic [NUM_STAGES*ADDR_WIDTH-1:0] st_addrA,
  input  logic [NUM_STAGES*ADDR_WIDTH-1:0] st_addrB,
  input  logic [NUM_STAGES-1:0]            st_wr_enaA,
  input  logic [NUM_STAGES-1:0]            st_wr_enaB,
  input  logic [NUM_STAGES*DATA_WIDTH-1:0] st_dataA,
  input  logic [NUM_STAGES*DATA_WIDTH-1:0] st_dataB,
  output logic [ADDR_WIDTH-1:0]            addrA,
  output logic [ADDR_WIDTH-1:0]            addrB,
  output logic                             wr_enaA,
  output logic                             wr_enaB,
  output logic [DATA_WIDTH-1:0]            ram_inA,
  output logic [DATA_WIDTH-1:0]            ram_inB,
  output logic                             busy,
  output logic                             done,
  output logic                             error,
  output logic [ERR_STAGE_W-1:0]           err_stage
);

  localparam logic [TIMEOUT_WIDTH-1:0] TO_ZERO = {TIMEOUT_WIDTH{1'b0}};
  localparam logic [TIMEOUT_WIDTH-1:0] TO_ONE  = TIMEOUT_WIDTH'(1);

  seq_state_t                 state_r, state_n;
  logic [ERR_STAGE_W-1:0]     cur_r, cur_n;
  logic [NUM_STAGES-1:0]      mask_r, mask_n;
  logic [TIMEOUT_WIDTH-1:0]   timeout_r, timeout_n;
  logic [TIMEOUT_WIDTH-1:0]   cnt_r, cnt_n;
  logic [NUM_STAGES-1:0]      st_ena_r, st_ena_n;
  logic                       busy_r, busy_n;
  logic                       done_r, done_n;
  logic                       error_r, error_n;
  logic [ERR_STAGE_W-1:0]     err_stage_r, err_stage_n;
  logic [MAX_STAGES-1:0]      fin_pad_s;
  logic                       expire_s;
  stage_pick_t                pick_s;
  logic [NUM_STAGES-1:0]      sel_s;
  logic                       bus_valid_s;

  // Widen the finished vector so any 4-bit stage index selects cleanly
  assign fin_pad_s = MAX_STAGES'(st_finished);

  // Watchdog fires on the last allowed RUN cycle; timeout of zero disables it
  assign expire_s = (timeout_r != TO_ZERO) && (cnt_r == (timeout_r - TO_ONE));

  // Next-state, stage selection, watchdog and status decode
  always_comb begin
    state_n     = state_r;
    cur_n       = cur_r;
    mask_n      = mask_r;
    timeout_n   = timeout_r;
    error_n     = error_r;
    err_stage_n = err_stage_r;
    pick_s      = '{found: 1'b0, idx: {ERR_STAGE_W{1'b0}}};

    case (state_r)
      S_IDLE, S_ERR: begin
        if (start) begin
          mask_n    = stage_mask;
          timeout_n = timeout;
          error_n   = 1'b0;
          pick_s    = next_set_bit(MAX_STAGES'(stage_mask), {(ERR_STAGE_W+1){1'b0}});
          if (pick_s.found) begin
            cur_n   = pick_s.idx;
            state_n = S_RUN;
          end else begin
            cur_n   = {ERR_STAGE_W{1'b0}};
            state_n = S_DONE;
          end
        end else begin
          state_n = state_r;
        end
      end
      S_RUN: begin
        // A finishing stage beats a watchdog expiry in the same cycle
        if (fin_pad_s[cur_r]) begin
          state_n = S_NEXT;
        end else if (expire_s) begin
          state_n     = S_ERR;
          error_n     = 1'b1;
          err_stage_n = cur_r;
        end else begin
          state_n = S_RUN;
        end
      end
      S_NEXT: begin
        pick_s = next_set_bit(MAX_STAGES'(mask_r), {1'b0, cur_r} + 5'd1);
        if (pick_s.found) begin
          cur_n   = pick_s.idx;
          state_n = S_RUN;
        end else begin
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    if ((state_r == S_RUN) && (state_n == S_RUN)) begin
      cnt_n = cnt_r + TO_ONE;
    end else begin
      cnt_n = TO_ZERO;
    end

    if (state_n == S_RUN) begin
      st_ena_n = NUM_STAGES'(16'd1 << cur_n);
    end else begin
      st_ena_n = {NUM_STAGES{1'b0}};
    end

    busy_n = (state_n == S_RUN) || (state_n == S_NEXT) || (state_n == S_DONE);
    done_n = (state_n == S_DONE);
  end

  // State, latched sequence settings, watchdog counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      cur_r       <= {ERR_STAGE_W{1'b0}};
      mask_r      <= {NUM_STAGES{1'b0}};
      timeout_r   <= TO_ZERO;
      cnt_r       <= TO_ZERO;
      st_ena_r    <= {NUM_STAGES{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
      err_stage_r <= {ERR_STAGE_W{1'b0}};
    end else begin
      state_r     <= state_n;
      cur_r       <= cur_n;
      mask_r      <= mask_n;
      timeout_r   <= timeout_n;
      cnt_r       <= cnt_n;
      st_ena_r    <= st_ena_n;
      busy_r      <= busy_n;
      done_r      <= done_n;
      error_r     <= error_n;
      err_stage_r <= err_stage_n;
    end
  end

  assign st_ena    = st_ena_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign error     = error_r;
  assign err_stage = err_stage_r;

  // RAM ports follow the current stage only while it is running
  assign sel_s       = NUM_STAGES'(16'd1 << cur_r);
  assign bus_valid_s = (state_r == S_RUN);

  stage_bus_mux #(
    .NUM_STAGES (NUM_STAGES),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_bus_mux (
    .sel       (sel_s),
    .valid     (bus_valid_s),
    .st_addr_a (st_addrA),
    .st_addr_b (st_addrB),
    .st_we_a   (st_wr_enaA),
    .st_we_b   (st_wr_enaB),
    .st_data_a (st_dataA),
    .st_data_b (st_dataB),
    .addr_a    (addrA),
    .addr_b    (addrB),
    .we_a      (wr_enaA),
    .we_b      (wr_enaB),
    .data_a    (ram_inA),
    .data_b    (ram_inB)
  );

endmodule

// File: tb/tb_ram_stage_sequencer.sv
// Self-checking bench for ram_stage_sequencer: per-cycle expected output
// traces are queued when a sequence is started and compared as it runs.
module tb_ram_stage_sequencer;

  localparam int NS = 3;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TW = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [NS-1:0]    stage_mask;
  logic [TW-1:0]    timeout;
  logic [NS-1:0]    st_ena;
  logic [NS-1:0]    st_finished;
  logic [NS*AW-1:0] st_addrA, st_addrB;
  logic [NS-1:0]    st_wr_enaA, st_wr_enaB;
  logic [NS*DW-1:0] st_dataA, st_dataB;
  logic [AW-1:0]    addrA, addrB;
  logic             wr_enaA, wr_enaB;
  logic [DW-1:0]    ram_inA, ram_inB;
  logic             busy, done, error;
  logic [3:0]       err_stage;

  ram_stage_sequencer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_STAGES(NS), .TIMEOUT_WIDTH(TW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stage_mask(stage_mask), .timeout(timeout),
    .st_ena(st_ena), .st_finished(st_finished),
    .st_addrA(st_addrA), .st_addrB(st_addrB),
    .st_wr_enaA(st_wr_enaA), .st_wr_enaB(st_wr_enaB),
    .st_dataA(st_dataA), .st_dataB(st_dataB),
    .addrA(addrA), .addrB(addrB), .wr_enaA(wr_enaA), .wr_enaB(wr_enaB),
    .ram_inA(ram_inA), .ram_inB(ram_inB),
    .busy(busy), .done(done), .error(error), .err_stage(err_stage)
  );

  always #5 clk = ~clk;

  // Per-stage stimulus values and behavioural stage models
  logic [AW-1:0] s_aa [NS];
  logic [AW-1:0] s_ab [NS];
  logic          s_wa [NS];
  logic          s_wb [NS];
  logic [DW-1:0] s_da [NS];
  logic [DW-1:0] s_db [NS];
  int            fin_after [NS];
  int            run_cnt [NS];
  logic [NS-1:0] fin_force;

  // Pack per-stage values onto the flattened buses
  always_comb begin
    for (int k = 0; k < NS; k++) begin
      st_addrA[k*AW +: AW] = s_aa[k];
      st_addrB[k*AW +: AW] = s_ab[k];
      st_wr_enaA[k]        = s_wa[k];
      st_wr_enaB[k]        = s_wb[k];
      st_dataA[k*DW +: DW] = s_da[k];
      st_dataB[k*DW +: DW] = s_db[k];
    end
  end

  // Count enabled cycles per stage
  always @(posedge clk) begin
    for (int k = 0; k < NS; k++) begin
      run_cnt[k] <= st_ena[k] ? run_cnt[k] + 1 : 0;
    end
  end

  // Stage k finishes on its fin_after[k]-th enabled cycle (0 = never)
  always_comb begin
    st_finished = '0;
    for (int k = 0; k < NS; k++) begin
      st_finished[k] = fin_force[k] |
                       (st_ena[k] && (fin_after[k] != 0) && (run_cnt[k] == fin_after[k] - 1));
    end
  end

  typedef struct packed {
    logic [NS-1:0] ena;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW-1:0] aa;
    logic [AW-1:0] ab;
    logic          wa;
    logic          wb;
    logic [DW-1:0] da;
    logic [DW-1:0] db;
  } exp_t;

  exp_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;
  string test_name = "init";

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s/%s actual=%0h expected=%0h at %0t", test_name, tag, act, expv, $time);
    end
  endtask

  // Build one expected output cycle; k<0 means RAM ports idle
  function automatic exp_t mk(input logic [NS-1:0] ena, input logic b, input logic d,
                              input logic e, input int k);
    exp_t r;
    r = '0;
    r.ena = ena; r.busy = b; r.done = d; r.error = e;
    if (k >= 0) begin
      r.aa = s_aa[k]; r.ab = s_ab[k]; r.wa = s_wa[k]; r.wb = s_wb[k];
      r.da = s_da[k]; r.db = s_db[k];
    end
    return r;
  endfunction

  // Queue the expected trace of one sequence, starting the cycle after start
  task automatic push_seq(input logic [NS-1:0] mask, input int to);
    logic [NS-1:0] oh;
    for (int k = 0; k < NS; k++) begin
      if (mask[k]) begin
        oh = NS'(1) << k;
        if (to != 0 && (fin_after[k] == 0 || fin_after[k] > to)) begin
          repeat (to) exp_q.push_back(mk(oh, 1'b1, 1'b0, 1'b0, k));
          exp_q.push_back(mk('0, 1'b0, 1'b0, 1'b1, -1));
          exp_q.push_back(mk('0, 1'b0, 1'b0, 1'b1, -1));
          return;
        end
        repeat (fin_after[k]) exp_q.push_back(mk(oh, 1'b1, 1'b0, 1'b0, k));
        exp_q.push_back(mk('0, 1'b1, 1'b0, 1'b0, -1));
      end
    end
    exp_q.push_back(mk('0, 1'b1, 1'b1, 1'b0, -1));
    exp_q.push_back(mk('0, 1'b0, 1'b0, 1'b0, -1));
  endtask

  // Advance one cycle and compare against the next queued expectation
  task automatic cycle_chk();
    exp_t e;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    chk("st_ena",  64'(st_ena),  64'(e.ena));
    chk("busy",    64'(busy),    64'(e.busy));
    chk("done",    64'(done),    64'(e.done));
    chk("error",   64'(error),   64'(e.error));
    chk("addrA",   64'(addrA),   64'(e.aa));
    chk("addrB",   64'(addrB),   64'(e.ab));
    chk("wr_enaA", 64'(wr_enaA), 64'(e.wa));
    chk("wr_enaB", 64'(wr_enaB), 64'(e.wb));
    chk("ram_inA", 64'(ram_inA), 64'(e.da));
    chk("ram_inB", 64'(ram_inB), 64'(e.db));
  endtask

  task automatic zero_chk(input string tag);
    chk({tag, ".st_ena"},    64'(st_ena),    64'd0);
    chk({tag, ".busy"},      64'(busy),      64'd0);
    chk({tag, ".done"},      64'(done),      64'd0);
    chk({tag, ".error"},     64'(error),     64'd0);
    chk({tag, ".err_stage"}, 64'(err_stage), 64'd0);
    chk({tag, ".addrA"},     64'(addrA),     64'd0);
    chk({tag, ".addrB"},     64'(addrB),     64'd0);
    chk({tag, ".wr_en"},     64'({wr_enaA, wr_enaB}), 64'd0);
    chk({tag, ".ram_inA"},   64'(ram_inA),   64'd0);
    chk({tag, ".ram_inB"},   64'(ram_inB),   64'd0);
  endtask

  task automatic rand_stages();
    for (int k = 0; k < NS; k++) begin
      s_aa[k] = AW'($urandom); s_ab[k] = AW'($urandom);
      s_wa[k] = 1'($urandom);  s_wb[k] = 1'($urandom);
      s_da[k] = $urandom;      s_db[k] = $urandom;
    end
  endtask

  // Start a sequence at a negedge and follow its whole expected trace
  task automatic run_seq(input string name, input logic [NS-1:0] mask, input int to,
                         input int f0, input int f1, input int f2);
    test_name = name;
    fin_after[0] = f0; fin_after[1] = f1; fin_after[2] = f2;
    rand_stages();
    stage_mask = mask;
    timeout    = TW'(to);
    push_seq(mask, to);
    start = 1'b1;
    while (exp_q.size() > 0) cycle_chk();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stage_mask = '0; timeout = '0; fin_force = '0;
    for (int k = 0; k < NS; k++) fin_after[k] = 0;
    rand_stages();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    zero_chk("reset");

    run_seq("all3",  3'b111, 0, 5, 7, 9);

    fin_force = 3'b010;
    run_seq("skip1", 3'b101, 0, 4, 1, 3);
    fin_force = 3'b000;

    run_seq("mask0", 3'b000, 0, 2, 2, 2);

    run_seq("wdog",  3'b111, 4, 3, 0, 5);
    test_name = "wdog";
    chk("err_stage", 64'(err_stage), 64'd1);
    run_seq("clr_err", 3'b000, 0, 0, 0, 0);

    run_seq("tie",   3'b011, 5, 5, 2, 0);

    // Start while busy is ignored, then reset mid-RUN beats a new start
    test_name = "busy_rst";
    fin_after[0] = 8; fin_after[1] = 8; fin_after[2] = 0;
    rand_stages();
    stage_mask = 3'b011; timeout = '0;
    push_seq(3'b011, 0);
    start = 1'b1;
    repeat (3) cycle_chk();
    stage_mask = 3'b100; start = 1'b1;
    repeat (2) cycle_chk();
    exp_q.delete();
    rst = 1'b1; start = 1'b1; stage_mask = 3'b001;
    @(posedge clk);
    #1 rst = 1'b0; start = 1'b0;
    @(negedge clk);
    zero_chk("after_rst");
    @(negedge clk);
    zero_chk("idle_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
